rs_trig_seq: RTL

RS_TRIG_SEQ -- requirements
Module: rs_trig_seq

---
 rtl/rs_trig_pkg.sv | 23 ++
 rtl/rs_rr_arb.sv | 38 +++
 rtl/rs_trig_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rs_trig_pkg.sv
// rtl/rs_trig_pkg.sv - shared types and default constants for the RS trigger sequencer
//
// Purpose: FSM state enum, operation enum and default parameter values used by
//          rs_trig_seq. No ports.
package rs_trig_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    ACK   = 2'd3
  } state_e;

  // Encoding doubles as the RS target level: 1 drives Q high, 0 drives Q low.
  typedef enum logic {
    OP_CLR = 1'b0,
    OP_SET = 1'b1
  } op_e;

  localparam int PULSE_W_DEF = 2;
  localparam int TIMEOUT_DEF = 8;

endpackage

// File: rtl/rs_rr_arb.sv
// rtl/rs_rr_arb.sv - two-way round-robin arbiter between set and clear requests
//
// Purpose: picks one of two requests; on a tie the op not granted last wins.
// Ports:
//   clk, rst   clock and sync active-high reset
//   req[1:0]   bit 0 = set request, bit 1 = clear request
//   update     record gnt as the most recent grant
//   gnt[1:0]   one-hot grant (combinational), 0 when no request
module rs_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 1 = last grant went to set. Reset to clear so set wins the first tie.
  logic last_set_q;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_set_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_set_q <= 1'b0;
    end else if (update) begin
      last_set_q <= gnt[0];
    end
  end

endmodule

// File: rtl/rs_trig_seq.sv
// rtl/rs_trig_seq.sv - sequencer that drives an external gated RS trigger to a requested level
//
// Purpose: grants set/clear requests round-robin, pulses C with S or R for
//          PULSE_W cycles, waits for Q_fb to match, then acks the requester.
// Build option: RS_TIMEOUT_EN adds a TIMEOUT-cycle limit on the wait and the
//          sticky err flag; without it the wait is unbounded and err is 0.
// Ports:
//   clk, rst            clock and sync active-high reset
//   set_req, clr_req    level requests, held until the matching ack
//   Q_fb                Q output of the controlled trigger
//   C, S, R             trigger gate, set and reset inputs
//   set_ack, clr_ack    one-cycle completion pulses
//   busy                high whenever the FSM is not idle
//   err                 sticky timeout flag
module rs_trig_seq
  import rs_trig_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  input  logic Q_fb,
  output logic C,
  output logic S,
  output logic R,
  output logic set_ack,
  output logic clr_ack,
  output logic busy,
  output logic err
);

  localparam logic [3:0] PW_LAST = 4'(PULSE_W - 1);

  state_e     state_q, state_d;
  op_e        op_q, op_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic [1:0] arb_req;
  logic [1:0] gnt;
  logic       target;
  logic       timed_out;

  assign target = (op_q == OP_SET);

  // Outside IDLE the arbiter sees only the op in flight, so in ACK its gnt
  // names that op and update records it, regardless of live request levels.
  assign arb_req = (state_q == IDLE) ? {clr_req, set_req}
                                     : (target ? 2'b01 : 2'b10);

  rs_rr_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (arb_req),
    .update (state_q == ACK),
    .gnt    (gnt)
  );

`ifdef RS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tcnt_q, tcnt_d;
  logic       err_q;

  assign timed_out = (state_q == CHECK) && (Q_fb != target) && (tcnt_q == TO_LAST);

  always_comb begin
    tcnt_d = '0;
    if (state_q == CHECK && Q_fb != target && !timed_out) begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  // TIMEOUT has no effect in this build; referenced only so it is not dangling.
  localparam int timeout_unused = TIMEOUT;

  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          op_d    = gnt[0] ? OP_SET : OP_CLR;
          pcnt_d  = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (pcnt_q == PW_LAST) begin
          pcnt_d  = '0;
          state_d = CHECK;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      CHECK: begin
        if (Q_fb == target || timed_out) begin
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_CLR;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      pcnt_q  <= pcnt_d;
    end
  end

  // Pure decode of registered state: S and R are mutually exclusive by
  // construction and all three are 0 whenever state is not DRIVE.
  assign C       = (state_q == DRIVE);
  assign S       = C & target;
  assign R       = C & ~target;
  assign set_ack = (state_q == ACK) & target;
  assign clr_ack = (state_q == ACK) & ~target;
  assign busy    = (state_q != IDLE);

endmodule
